// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: one FIPS 180-4 round per clock, 16-word rolling
// message schedule, external combinational K-constant ROM addressed by k_idx.
module sha256_round_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         init,
  input  logic [511:0] block,
  output logic         ready,
  output logic [5:0]   k_idx,
  input  logic [31:0]  k_in,
  output logic [255:0] digest,
  output logic         digest_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  t;
  logic [31:0] win [16];
  logic [31:0] wk  [8];
  logic [31:0] hreg [8];
  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Round arithmetic; wk[0..7] hold a..h.
  always_comb begin
    t1    = wk[7] + big_sigma1(wk[4]) + ch(wk[4], wk[5], wk[6]) + k_in + win[0];
    t2    = big_sigma0(wk[0]) + maj(wk[0], wk[1], wk[2]);
    w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    k_idx     = 6'd0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = ROUND;
      end
      ROUND: begin
        k_idx = t;
        if (t == 6'd63) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t            <= 6'd0;
      digest_valid <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        wk[i]   <= 32'd0;
        hreg[i] <= IV[255 - 32*i -: 32];
      end
    end else begin
      digest_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            t <= 6'd0;
            for (int i = 0; i < 16; i++) win[i] <= block[511 - 32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              if (init) begin
                hreg[i] <= IV[255 - 32*i -: 32];
                wk[i]   <= IV[255 - 32*i -: 32];
              end else begin
                wk[i] <= hreg[i];
              end
            end
          end
        end
        ROUND: begin
          // t wraps to 0 on the last round; the FSM leaves ROUND on that edge.
          t <= t + 6'd1;
          for (int i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15] <= w_new;
          wk[0] <= t1 + t2;
          wk[1] <= wk[0];
          wk[2] <= wk[1];
          wk[3] <= wk[2];
          wk[4] <= wk[3] + t1;
          wk[5] <= wk[4];
          wk[6] <= wk[5];
          wk[7] <= wk[6];
        end
        DONE: begin
          for (int i = 0; i < 8; i++) hreg[i] <= hreg[i] + wk[i];
          digest_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign digest = {hreg[0], hreg[1], hreg[2], hreg[3],
                   hreg[4], hreg[5], hreg[6], hreg[7]};

endmodule

// File: tb/tb_sha256_round_engine.sv
// Scoreboard bench for sha256_round_engine: a driver issues blocks and queues the
// expected digest and arrival cycle; a monitor pops and checks on digest_valid.
module tb_sha256_round_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         init;
  logic [511:0] block;
  logic         ready;
  logic [5:0]   k_idx;
  logic [31:0]  k_in;
  logic [255:0] digest;
  logic         digest_valid;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [255:0] dig;
    int unsigned  at;
  } exp_t;

  exp_t         sbq [$];
  logic [255:0] model_h;
  int           n_tests = 0;
  int           n_fail  = 0;
  int unsigned  cyc     = 0;

  sha256_round_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .init         (init),
    .block        (block),
    .ready        (ready),
    .k_idx        (k_idx),
    .k_in         (k_in),
    .digest       (digest),
    .digest_valid (digest_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb k_in = kt[k_idx];

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  // Straight FIPS 180-4 compression with the full 64-word schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, x, y, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32*i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int i = 0; i < 64; i++) begin
      x = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kt[i] + w[i];
      y = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + x;
      d = c; c = b; b = a; a = x + y;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
            hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready; with noise, toggles start/block/init while busy.
  task automatic wait_ready(input bit noise);
    int n = 0;
    while (!ready) begin
      if (n > 200) begin
        chk("ready_timeout", 256'(ready), 256'(1));
        return;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        init  = 1'($urandom_range(0, 1));
        block = rand512();
      end
      step();
      n++;
    end
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [255:0] dig);
    exp_t e;
    e.dig = dig;
    e.at  = cyc + 66;
    sbq.push_back(e);
    model_h = dig;
  endtask

  task automatic issue(input logic [511:0] blk, input logic ini, input logic [255:0] exp_dig);
    wait_ready(1'b0);
    start = 1'b1;
    block = blk;
    init  = ini;
    push_exp(exp_dig);
    step();
    start = 1'b0;
    block = rand512();
    init  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", 256'(sbq.size()), 256'(0));
    step();
  endtask

  // Monitor: every digest_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && digest_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 256'(digest_valid), 256'(0));
      end else begin
        e = sbq.pop_front();
        chk("digest", digest, e.dig);
        chk("latency", 256'(cyc), 256'(e.at));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk;
    logic [255:0] exp_dig;
    logic         ini;
    int           n;

    rst     = 1'b1;
    start   = 1'b0;
    init    = 1'b0;
    block   = '0;
    model_h = IV;
    #2;
    chk("rst_ready", 256'(ready), 256'(1));
    chk("rst_k_idx", 256'(k_idx), 256'(0));
    chk("rst_digest", digest, IV);
    chk("rst_valid", 256'(digest_valid), 256'(0));
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", 256'(ready), 256'(1));
    chk("post_rst_digest", digest, IV);

    // "abc" with k_idx trace and digest stability during rounds
    issue(ABC_BLK, 1'b1, ABC_DIG);
    for (int i = 0; i < 64; i++) begin
      chk("k_idx_trace", 256'(k_idx), 256'(i));
      if (i == 0 || i == 40) begin
        chk("busy_not_ready", 256'(ready), 256'(0));
        chk("digest_stable", digest, IV);
      end
      step();
    end
    chk("k_idx_done", 256'(k_idx), 256'(0));
    drain();

    // Empty message, with start noise while busy
    issue(EMPTY_BLK, 1'b1, EMPTY_DIG);
    wait_ready(1'b1);
    drain();

    // Two-block message, second block issued in the digest_valid cycle
    issue(TWO_B1, 1'b1, compress(IV, TWO_B1));
    wait_ready(1'b0);
    chk("b2b_valid_cycle", 256'(digest_valid), 256'(1));
    issue(TWO_B2, 1'b0, TWO_DIG);
    drain();
    chk("two_block_final", digest, TWO_DIG);

    // Random chains, back-to-back with noise while busy
    for (int r = 0; r < 6; r++) begin
      ini     = (r == 0) || ($urandom_range(0, 2) == 0);
      blk     = rand512();
      exp_dig = compress(ini ? IV : model_h, blk);
      issue(blk, ini, exp_dig);
      wait_ready(1'b1);
    end
    drain();

    // start held high throughout; block changed at cycle 10
    wait_ready(1'b0);
    start = 1'b1;
    init  = 1'b1;
    block = ABC_BLK;
    push_exp(ABC_DIG);
    step();
    blk = rand512();
    n   = 1;
    while (!ready && n < 200) begin
      if (n == 10) block = blk;
      step();
      n++;
    end
    chk("held_start_ready", 256'(ready), 256'(1));
    push_exp(compress(IV, blk));
    step();
    start = 1'b0;
    drain();

    // Reset in the middle of the rounds
    issue(ABC_BLK, 1'b1, ABC_DIG);
    for (int i = 0; i < 30; i++) step();
    chk("abort_round", 256'(k_idx), 256'(30));
    rst = 1'b1;
    sbq.delete();
    model_h = IV;
    #1;
    chk("abort_ready", 256'(ready), 256'(1));
    chk("abort_k_idx", 256'(k_idx), 256'(0));
    chk("abort_digest", digest, IV);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 80; i++) step();
    chk("after_abort_ready", 256'(ready), 256'(1));
    chk("after_abort_digest", digest, IV);
    issue(ABC_BLK, 1'b1, ABC_DIG);
    drain();
    chk("final_abc", digest, ABC_DIG);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
